// File: rtl/logic_gate_pkg.sv
// Shared types and helpers for the logic_gate leaf primitive: the gate function
// enum, a one-bit evaluator and the glitch-filter counter limits.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } gate_op_e;

    localparam int FILTER_LEN_MAX = 255;
    localparam int CNT_W          = $clog2(FILTER_LEN_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic op_is_legal(gate_op_e op);
        return op inside {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR};
    endfunction

    function automatic logic gate_eval(gate_op_e op, logic a, logic b);
        logic r;
        r = 1'b0;
        unique case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_filter.sv
// gate_filter: single-bit debounce. q follows d only after d has differed from
// q on FILTER_LEN consecutive rising edges; any return to q restarts the run.
module gate_filter
    import logic_gate_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam cnt_t RUN_LIMIT = cnt_t'(FILTER_LEN);

    cnt_t run_cnt;
    cnt_t run_next;
    logic q_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
        run_next = '0;
        q_next   = q;
        if (d != q) begin
            // Saturate instead of wrapping so a long disagreement can never alias to a short one.
            run_next = (run_cnt == RUN_LIMIT) ? run_cnt : run_cnt + 1'b1;
            if (run_next == RUN_LIMIT) begin
                q_next   = d;
                run_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            q       <= 1'b0;
            run_cnt <= '0;
        end else begin
            q       <= q_next;
            run_cnt <= run_next;
        end
    end

endmodule

// File: rtl/logic_gate.sv
// logic_gate: registered bitwise two-input gate, z = OP(x, y) per bit.
// Define LOGIC_GATE_FILTER_EN to debounce every x/y bit before evaluation.
module logic_gate
    import logic_gate_pkg::*;
#(
    parameter int       WIDTH      = 1,
    parameter gate_op_e OP         = OP_AND,
    parameter int       FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    if (!op_is_legal(OP)) begin : g_bad_op
        initial $fatal(1, "logic_gate: illegal OP value %0d", OP);
    end

    if (FILTER_LEN < 1 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filter_len
        initial $fatal(1, "logic_gate: FILTER_LEN %0d outside 1..%0d", FILTER_LEN, FILTER_LEN_MAX);
    end

    logic [WIDTH-1:0] x_f;
    logic [WIDTH-1:0] y_f;
    logic [WIDTH-1:0] z_next;

`ifdef LOGIC_GATE_FILTER_EN
    // Operands are debounced independently, so z may briefly show a mixed value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_filter
        gate_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_x (
            .clk (clk),
            .rst (rst),
            .d   (x[i]),
            .q   (x_f[i])
        );
        gate_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_y (
            .clk (clk),
            .rst (rst),
            .d   (y[i]),
            .q   (y_f[i])
        );
    end
`else
    assign x_f = x;
    assign y_f = y;
`endif

    always_comb begin
        z_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            z_next[i] = gate_eval(OP, x_f[i], y_f[i]);
        end
    end

    // z always comes from this flop, keeping it glitch-free and defined out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            z <= '0;
        end else begin
            z <= z_next;
        end
    end

endmodule

// File: tb/tb_logic_gate.sv
// Self-checking bench for logic_gate: directed truth-table vectors, reset and
// filter sequences, then randomized stimulus against a history-based model.
module tb_logic_gate;
    import logic_gate_pkg::*;

    localparam int FL = 4;
`ifdef LOGIC_GATE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT = FILT ? FL + 1 : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x1  = 1'b0;
    logic       y1  = 1'b0;
    logic [7:0] x8  = 8'h00;
    logic [7:0] y8  = 8'h00;
    wire  [5:0] z1;
    wire  [7:0] z8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        logic_gate #(.WIDTH(1), .OP(gate_op_e'(g)), .FILTER_LEN(FL)) u_dut (
            .clk (clk),
            .rst (rst),
            .x   (x1),
            .y   (y1),
            .z   (z1[g])
        );
    end

    logic_gate #(.WIDTH(8), .OP(OP_XOR), .FILTER_LEN(FL)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .x   (x8),
        .y   (y8),
        .z   (z8)
    );

    // Reference model: truth vectors indexed by {x,y}, plus a record of every sampled edge.
    logic [3:0] truth [6];

    typedef struct {
        logic       rst;
        logic       x1;
        logic       y1;
        logic [7:0] x8;
        logic [7:0] y8;
    } sample_t;

    sample_t hist[$];

    always @(posedge clk) hist.push_back('{rst, x1, y1, x8, y8});

    function automatic logic raw_bit(int k, bit wide, bit is_y, int b);
        if (wide) return is_y ? hist[k].y8[b] : hist[k].x8[b];
        return is_y ? hist[k].y1 : hist[k].x1;
    endfunction

    // Filtered value after edge k: the raw value of the latest FL-long constant,
    // reset-free window ending at or before k; 0 if a reset intervenes first.
    function automatic logic filt_bit(int k, bit wide, bit is_y, int b);
        for (int j = k; j >= 0; j--) begin
            bit   ok;
            logic v;
            if (hist[j].rst) return 1'b0;
            if (j - FL + 1 < 0) return 1'b0;
            v  = raw_bit(j, wide, is_y, b);
            ok = 1'b1;
            for (int m = j - FL + 1; m < j; m++) begin
                if (hist[m].rst || raw_bit(m, wide, is_y, b) !== v) ok = 1'b0;
            end
            if (ok) return v;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_z(int op, bit wide);
        int         k;
        int         w;
        logic [7:0] r;
        logic       a;
        logic       bb;
        k = hist.size() - 1;
        w = wide ? 8 : 1;
        r = '0;
        if (k < 0) return 8'h00;
        if (hist[k].rst) return 8'h00;
        for (int b = 0; b < w; b++) begin
            if (FILT) begin
                if (k == 0) return 8'h00;
                a  = filt_bit(k - 1, wide, 1'b0, b);
                bb = filt_bit(k - 1, wide, 1'b1, b);
            end else begin
                a  = raw_bit(k, wide, 1'b0, b);
                bb = raw_bit(k, wide, 1'b1, b);
            end
            r[b] = truth[op][{a, bb}];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Check one width-1 instance on each of the next lat edges: old value until the last, then new.
    task automatic expect_seq(input string name, input int op, input logic old_v,
                              input logic new_v, input int lat);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", name, i), {7'b0, z1[op]}, {7'b0, (i == lat) ? new_v : old_v});
        end
    endtask

    typedef struct {
        logic       x;
        logic       y;
        logic [5:0] exp;   // {XNOR, NOR, NAND, XOR, OR, AND}
    } vec_t;

    vec_t vecs[4];

    initial begin
        truth[0] = 4'b1000;  // AND  : 00/01/10/11 -> 0001
        truth[1] = 4'b1110;  // OR   : 0111
        truth[2] = 4'b0110;  // XOR  : 0110
        truth[3] = 4'b0111;  // NAND : 1110
        truth[4] = 4'b0001;  // NOR  : 1000
        truth[5] = 4'b1001;  // XNOR : 1001

        vecs[0] = '{1'b0, 1'b0, 6'b111000};
        vecs[1] = '{1'b0, 1'b1, 6'b001110};
        vecs[2] = '{1'b1, 1'b0, 6'b001110};
        vecs[3] = '{1'b1, 1'b1, 6'b100011};

        // Reset held three cycles, then basic AND sequencing.
        repeat (3) @(negedge clk);
        check("reset_z1", {2'b0, z1}, 8'h00);
        check("reset_z8", z8, 8'h00);
        rst = 1'b0;
        expect_seq("t1_release", 0, 1'b0, 1'b0, LAT);
        x1 = 1'b1;
        expect_seq("t1_x_only", 0, 1'b0, 1'b0, LAT + 2);
        y1 = 1'b1;
        expect_seq("t1_y_rise", 0, 1'b0, 1'b1, LAT);
        x1 = 1'b0;
        expect_seq("t1_x_fall", 0, 1'b1, 1'b0, LAT);

        // Every function over all four input pairs.
        for (int i = 0; i < 4; i++) begin
            x1 = vecs[i].x;
            y1 = vecs[i].y;
            repeat (LAT) @(negedge clk);
            check($sformatf("t2_xy%0d", i), {2'b0, z1}, {2'b0, vecs[i].exp});
        end

        // Wide XOR.
        x8 = 8'hA5;
        y8 = 8'h0F;
        repeat (LAT) @(negedge clk);
        check("t3_xor8", z8, 8'hAA);

`ifdef LOGIC_GATE_FILTER_EN
        // Short pulse is swallowed; a stable change appears FL+1 edges later.
        x1 = 1'b1;
        y1 = 1'b0;
        repeat (LAT) @(negedge clk);
        check("t4_idle", {7'b0, z1[0]}, 8'h00);
        y1 = 1'b1;
        repeat (3) @(negedge clk);
        y1 = 1'b0;
        expect_seq("t4_pulse", 0, 1'b0, 1'b0, 8);
        y1 = 1'b1;
        expect_seq("t4_stable", 0, 1'b0, 1'b1, FL + 1);
`endif

        // Reset mid-operation with inputs held high.
        x1 = 1'b1;
        y1 = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        check("t5_before", {7'b0, z1[0]}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_reset", {7'b0, z1[0]}, 8'h00);
        rst = 1'b0;
        expect_seq("t5_release", 0, 1'b0, 1'b1, LAT);

        // NAND: 0 during reset, 1 at the first edge after release.
        x1 = 1'b0;
        y1 = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_nand_reset", {7'b0, z1[3]}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("t6_nand_release", {7'b0, z1[3]}, 8'h01);

        // Randomized stimulus against the model, including occasional resets.
        for (int n = 0; n < 400; n++) begin
            for (int op = 0; op < 6; op++) begin
                check($sformatf("rand_op%0d", op), {7'b0, z1[op]}, model_z(op, 1'b0));
            end
            check("rand_xor8", z8, model_z(2, 1'b1));
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 4) == 0) x1 = 1'($urandom);
            if ($urandom_range(0, 4) == 0) y1 = 1'($urandom);
            if ($urandom_range(0, 4) == 0) x8 = 8'($urandom);
            if ($urandom_range(0, 4) == 0) y8 = 8'($urandom);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_gate.md
# logic_gate

Clocked two-input bitwise logic gate. Combines operands `x` and `y` with a build-time-selected Boolean function and drives the registered result on `z`. Used as a leaf primitive wherever a glitch-free, reset-defined logic result is needed on a single clock domain. An optional input glitch filter can be compiled in.

## Interface
Parameters:
- `WIDTH`, default 1: operand and result width in bits.
- `OP`, default `OP_AND`: gate function, type `logic_gate_pkg::gate_op_e`. Legal values: `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NAND`, `OP_NOR`, `OP_XNOR`.
- `FILTER_LEN`, default 4: required input stability in cycles, range 1–255. Used only when `LOGIC_GATE_FILTER_EN` is defined.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `x`, input, WIDTH: operand A. Synchronous to `clk`.
- `y`, input, WIDTH: operand B. Synchronous to `clk`.
- `z`, output, WIDTH: registered result `OP(x, y)`, applied bitwise.

## Operation
- Each bit position is independent: `z[i] = OP(x[i], y[i])`.
- Truth for `x,y = 00/01/10/11`:
  - AND: 0001.
  - OR: 0111.
  - XOR: 0110.
  - NAND: 1110.
  - NOR: 1000.
  - XNOR: 1001.
- `z` is always taken from a flop and never driven combinationally from the inputs.
- Reset: while `rst`=1 at a rising edge, `z` ← 0 regardless of `OP`, and all filter state clears to 0. Reset overrides every other event in the same cycle.
- Inputs are not metastability-synchronized. Callers must present synchronous signals.
- An illegal `OP` value is a fatal elaboration error (`$fatal` in an initial block).

## Timing
- Without filter: latency is 1 cycle. `z` at edge n+1 equals `OP` of `x`, `y` sampled at edge n.
- With filter:
  - Each input bit has a stable-value register and a run counter.
  - The stable value takes a new sample only after the raw bit has differed from it for `FILTER_LEN` consecutive edges.
  - Any return to the stable value before then resets the counter to 0.
  - `z` is registered from the filtered bits.
  - Worst-case latency from a raw change to `z` is `FILTER_LEN`+1 cycles.
  - With `FILTER_LEN`=1, behavior is identical to the unfiltered 1-cycle latency plus one extra cycle (total 2).
- Simultaneous changes on `x` and `y` are filtered independently. `z` may show one intermediate value for a single cycle if the two inputs complete filtering on different edges.
- Deasserting reset: the first evaluated value appears at the first edge with `rst`=0. For example, NAND with inputs 0/0 gives `z`=1 one cycle after release in the unfiltered build.
- Run counters saturate at `FILTER_LEN` and never wrap.

## Configuration
- `LOGIC_GATE_FILTER_EN`:
  - Defined: the per-bit glitch filter is instantiated, and the latency rules above apply.
  - Undefined: no filter logic exists, `FILTER_LEN` is ignored, and latency is exactly 1 cycle.
- Port list is identical in both builds.

## Structure
- `logic_gate_pkg` holds:
  - the `gate_op_e` enum;
  - the function `gate_eval(op, a, b)` returning one bit;
  - the constant `FILTER_LEN_MAX` = 255.
- One sub-module, `gate_filter`: a single-bit debounce with a `FILTER_LEN` parameter and `clk`, `rst`, `d`, `q` ports. It is instantiated 2×WIDTH times under `LOGIC_GATE_FILTER_EN`.
- The top level contains the generate loop, the `OP` legality check and the output register.

## Test plan
1. Reset and sequencing (WIDTH=1, AND, unfiltered):
   - Hold `rst` for 3 cycles → `z`=0.
   - Release with x=0, y=0 → `z`=0.
   - Set x=1 → `z` stays 0.
   - Set y=1 → `z`=1 exactly 1 cycle later.
   - Set x=0 → `z`=0 1 cycle later.
2. All functions: for each `OP`, sweep x,y through 00, 01, 10, 11 → `z` matches the truth vectors above, each 1 cycle after the input is applied.
3. Width: WIDTH=8, XOR, x=0xA5, y=0x0F → `z`=0xAA after 1 cycle.
4. Filter (filter built in, `FILTER_LEN`=4, AND, x=1):
   - A 3-cycle pulse on y → `z` stays 0.
   - A 4-cycle-stable y=1 → `z`=1 exactly 5 cycles after the y change.
5. Reset mid-operation:
   - With `z`=1 (AND, x=y=1), assert `rst` for 1 cycle → `z`=0 at that edge.
   - Inputs held → `z`=1 again 1 cycle after release (unfiltered) or `FILTER_LEN`+1 cycles after release (filtered).
6. NAND reset value: with inputs at 0/0, `z`=0 during reset and 1 at the first edge after release (unfiltered).
